// File: rtl/pe_rx_checker_if.sv
// Handshake bundle between one NoC PE output port and its receive checker.
// The master drives packet data/valid; the slave (the checker) returns ready.
interface pe_rx_checker_if #(
  parameter int W = 36
);
  logic [W-1:0] i_data;
  logic         i_data_valid;
  logic         o_data_ready;

  modport master (output i_data, output i_data_valid, input o_data_ready);
  modport slave  (input i_data, input i_data_valid, output o_data_ready);
endinterface

// File: rtl/pe_rx_checker.sv
// Receive-side checker for one HNoC PE output port.
// Accepts packets {dest, src, seq}, checks the destination and per-source
// sequence order, and keeps saturating packet/error counts plus sticky
// error/done flags. o_done rises on the edge the packet count reaches ExpPkts.
// Optional macro RX_STALL_EN: an 8-bit LFSR throttles ready (~1/8 stall rate)
// to exercise NoC backpressure; left undefined, ready is high whenever running.
//
// state  | meaning
// S_INIT | clearing the sequence table one entry per cycle, ready low
// S_RUN  | accepting and checking packets
// S_DONE | ExpPkts reached; still accepting, every extra packet is an error
module pe_rx_checker #(
  parameter int address   = 0,
  parameter int numPE     = 16,
  parameter int AddrWidth = 4,
  parameter int DataWidth = 32,
  parameter int ExpPkts   = 100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pe_rx_checker_if.slave       rx,
  output logic [31:0]          o_pkt_count,
  output logic [15:0]          o_err_count,
  output logic                 o_err,
  output logic                 o_done
);

  localparam int SeqW = DataWidth - AddrWidth;
  localparam int PktW = DataWidth + AddrWidth;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   ptr_q, ptr_d;
  logic                   stg_vld_q, stg_vld_d;
  logic [PktW-1:0]        stg_data_q, stg_data_d;
  logic [31:0]            pkt_cnt_q, pkt_cnt_d;
  logic [15:0]            err_cnt_q, err_cnt_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;

  // Sequence table has no reset; S_INIT clears it after every reset.
  logic [SeqW-1:0]        seq_tbl [numPE];
  logic                   tbl_we;
  logic [AddrWidth-1:0]   tbl_idx;
  logic [SeqW-1:0]        tbl_wdata;

  logic                   ready;
  logic                   accept;
  logic [AddrWidth-1:0]   stg_dest;
  logic [AddrWidth-1:0]   stg_src;
  logic [SeqW-1:0]        stg_seq;
  logic [SeqW-1:0]        tbl_rd;
  logic                   pkt_err;

`ifdef RX_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 8,6,5,4, free-running every cycle.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // LFSR register, reseeded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'hA5;
    else        lfsr_q <= lfsr_d;
  end

  assign ready = (state_q != S_INIT) && (lfsr_q[2:0] != 3'b000);
`else
  assign ready = (state_q != S_INIT);
`endif

  assign rx.o_data_ready = ready;
  assign accept          = rx.i_data_valid & ready;

  assign stg_dest = stg_data_q[PktW-1 -: AddrWidth];
  assign stg_src  = stg_data_q[SeqW +: AddrWidth];
  assign stg_seq  = stg_data_q[SeqW-1:0];

  // The table write for a packet lands on the same edge the next packet is
  // staged, so a back-to-back packet from the same source reads the updated
  // entry without an explicit bypass.
  assign tbl_rd = seq_tbl[stg_src];

  // Stage register capture and table write selection / packet check.
  always_comb begin
    stg_vld_d  = accept;
    stg_data_d = accept ? rx.i_data : stg_data_q;
    tbl_we     = 1'b0;
    tbl_idx    = ptr_q;
    tbl_wdata  = '0;
    pkt_err    = 1'b0;
    if (state_q == S_INIT) begin
      tbl_we = 1'b1;
    end else if (stg_vld_q) begin
      if (stg_dest != AddrWidth'(address)) begin
        pkt_err = 1'b1;
      end else begin
        tbl_we  = 1'b1;
        tbl_idx = stg_src;
        if (stg_seq != tbl_rd) begin
          pkt_err   = 1'b1;
          tbl_wdata = stg_seq + 1'b1;
        end else begin
          tbl_wdata = tbl_rd + 1'b1;
        end
      end
      // Packets beyond the expected total are overflow errors.
      if (done_q) pkt_err = 1'b1;
    end
  end

  // Saturating counters, sticky flags and FSM next state.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    err_d     = err_q;
    done_d    = done_q;
    state_d   = state_q;
    ptr_d     = ptr_q;
    if (stg_vld_q) begin
      if (pkt_cnt_q != 32'hFFFF_FFFF) pkt_cnt_d = pkt_cnt_q + 32'd1;
      if (pkt_err) begin
        err_d = 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      end
      if ((pkt_cnt_d == 32'(ExpPkts)) && (pkt_cnt_q != 32'(ExpPkts))) done_d = 1'b1;
    end
    case (state_q)
      S_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == AddrWidth'(numPE - 1)) state_d = S_RUN;
      end
      S_RUN:   if (done_d) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_INIT;
    endcase
  end

  // Control, stage and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      ptr_q      <= '0;
      stg_vld_q  <= 1'b0;
      stg_data_q <= '0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      stg_vld_q  <= stg_vld_d;
      stg_data_q <= stg_data_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  // Sequence table write port (init clear or check update).
  always_ff @(posedge clk) begin
    if (tbl_we) seq_tbl[tbl_idx] <= tbl_wdata;
  end

  assign o_pkt_count = pkt_cnt_q;
  assign o_err_count = err_cnt_q;
  assign o_err       = err_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_pe_rx_checker.sv
// Bench for pe_rx_checker: directed packets, expected results queued by the
// driver and compared by a separate monitor one edge after each accept.
module tb_pe_rx_checker;
  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int W   = DW + AW;
  localparam int SW  = DW - AW;
  localparam int EXP = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] o_pkt_count;
  logic [15:0] o_err_count;
  logic        o_err;
  logic        o_done;

  always #5 clk = ~clk;

  pe_rx_checker_if #(.W(W)) rx ();

  pe_rx_checker #(
    .address(0), .numPE(16), .AddrWidth(AW), .DataWidth(DW), .ExpPkts(EXP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .o_pkt_count(o_pkt_count), .o_err_count(o_err_count),
    .o_err(o_err), .o_done(o_done)
  );

  typedef struct {
    logic [31:0] pkt;
    logic [15:0] errc;
    logic        err;
    logic        done;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_pkt = 0;
  int   m_errc = 0;
  bit   m_err = 1'b0;
  bit   m_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic model_clear();
    m_pkt = 0; m_errc = 0; m_err = 1'b0; m_done = 1'b0;
  endtask

  // Counts sample points (just before a rising edge) where ready is low.
  task automatic check_init();
    int cnt = 0;
    while (cnt < 100) begin
      @(negedge clk); #4;
      if (rx.o_data_ready) break;
      cnt++;
    end
    chk("init_ready_low_cycles", cnt, 16);
    chk("init_pkt_count", o_pkt_count, 0);
    chk("init_err_count", o_err_count, 0);
  endtask

  // Asserts reset now, checks outputs clear at once, releases after one edge.
  task automatic reset_pulse();
    rst_n = 1'b0;
    rx.i_data_valid = 1'b0;
    #1;
    chk("rst_pkt_count", o_pkt_count, 0);
    chk("rst_err_count", o_err_count, 0);
    chk("rst_err", o_err, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ready", rx.o_data_ready, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    model_clear();
    check_init();
  endtask

  // Presents one packet, waits for ready, returns at the transfer edge.
  task automatic send(input logic [AW-1:0] dest, input logic [AW-1:0] src,
                      input logic [SW-1:0] seq, input bit bad, input bit push);
    int waits = 0;
    exp_t e;
    @(negedge clk);
    rx.i_data_valid = 1'b1;
    rx.i_data = {dest, src, seq};
    while (!rx.o_data_ready && waits < 64) begin
      @(negedge clk);
      waits++;
    end
    if (!rx.o_data_ready) begin
      chk("send_ready_timeout", rx.o_data_ready, 1);
      rx.i_data_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) begin
      m_pkt++;
      if (bad) begin m_errc++; m_err = 1'b1; end
      if (m_pkt == EXP) m_done = 1'b1;
      e.pkt = 32'(m_pkt); e.errc = 16'(m_errc); e.err = m_err; e.done = m_done;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx.i_data_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: an accept seen before edge E is compared just after edge E+1.
  initial begin
    bit   pend = 1'b0;
    bit   acc;
    exp_t e;
    forever begin
      @(negedge clk); #4;
      acc = rx.i_data_valid && rx.o_data_ready && rst_n;
      @(posedge clk); #1;
      if (pend && rst_n) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_unexpected: output with pkt_count %0d but no expected entry", o_pkt_count);
        end else begin
          e = sb_q.pop_front();
          chk("sb_pkt_count", o_pkt_count, e.pkt);
          chk("sb_err_count", o_err_count, e.errc);
          chk("sb_err", o_err, e.err);
          chk("sb_done", o_done, e.done);
        end
      end
      pend = acc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rx.i_data_valid = 1'b0;
    rx.i_data = '0;
    #1;
    chk("por_pkt_count", o_pkt_count, 0);
    chk("por_err_count", o_err_count, 0);
    chk("por_err", o_err, 0);
    chk("por_done", o_done, 0);
    chk("por_ready", rx.o_data_ready, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    check_init();

    // Duplicate seq from src 3, then recovery.
    send(4'd0, 4'd3, 28'd0, 1'b0, 1'b1);
    send(4'd0, 4'd3, 28'd0, 1'b1, 1'b1);
    send(4'd0, 4'd3, 28'd1, 1'b0, 1'b1);
    // Wrong destination leaves src 5 entry at 0.
    send(4'd1, 4'd5, 28'd7, 1'b1, 1'b1);
    send(4'd0, 4'd5, 28'd0, 1'b0, 1'b1);
    idle(3);
    chk("dup_dest_err_count", o_err_count, 2);
    chk("dup_dest_err", o_err, 1);

    // Reset while a packet sits in the stage register; it must vanish.
    send(4'd0, 4'd3, 28'd2, 1'b0, 1'b0);
    #2;
    reset_pulse();
    // src 3 was at 2 before reset; re-cleared table accepts seq 0.
    send(4'd0, 4'd3, 28'd0, 1'b0, 1'b1);
    idle(3);

    @(posedge clk); #2;
    reset_pulse();
    for (int i = 0; i < EXP; i++) begin
      send(4'd0, AW'(i % 16), SW'(i / 16), 1'b0, 1'b1);
    end
    // Packet 101: sequence correct, but beyond the expected total.
    send(4'd0, 4'd0, 28'd7, 1'b1, 1'b1);
    idle(4);
    chk("ovf_pkt_count", o_pkt_count, 101);
    chk("ovf_err_count", o_err_count, 1);
    chk("ovf_done", o_done, 1);
    chk("done_ready", rx.o_data_ready, 1);
    chk("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
